// File: rtl/sevenseg_digit_counter.sv
// Prescaled BCD up/down digit counter with registered active-low 7-segment decode.
// Emits a tick per step and a carry on wrap so further digits can be chained.
module sevenseg_digit_counter #(
    parameter int unsigned TICK_DIV = 12_000_000,
    parameter int unsigned PW       = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up_dn,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       blank,
    output logic [3:0] digit,
    output logic       tick,
    output logic       carry,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g
);

    localparam logic [PW-1:0] PrescMax = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_presc;
    logic [3:0]    r_digit;
    logic          r_tick;
    logic          r_carry;
    logic [6:0]    r_seg;
    logic [6:0]    w_seg;
    logic          w_step;

    assign w_step = en && (r_presc == PrescMax);

    // Segment order a..g maps to bits 6..0; 0 lights a segment.
    always_comb begin
        w_seg = 7'b1111111;
        unique case (r_digit)
            4'd0:    w_seg = 7'b0000001;
            4'd1:    w_seg = 7'b1001111;
            4'd2:    w_seg = 7'b0010010;
            4'd3:    w_seg = 7'b0000110;
            4'd4:    w_seg = 7'b1001100;
            4'd5:    w_seg = 7'b0100100;
            4'd6:    w_seg = 7'b0100000;
            4'd7:    w_seg = 7'b0001111;
            4'd8:    w_seg = 7'b0000000;
            4'd9:    w_seg = 7'b0000100;
            default: w_seg = 7'b1111111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_digit <= 4'd0;
            r_tick  <= 1'b0;
            r_carry <= 1'b0;
            r_seg   <= 7'b0000001;
        end else begin
            r_tick  <= 1'b0;
            r_carry <= 1'b0;
            r_seg   <= blank ? 7'b1111111 : w_seg;
            if (load) begin
                // Out-of-range load values are ignored so the digit stays BCD.
                r_presc <= '0;
                if (load_val <= 4'd9) begin
                    r_digit <= load_val;
                end
            end else if (en) begin
                if (w_step) begin
                    r_presc <= '0;
                    r_tick  <= 1'b1;
                    if (up_dn) begin
                        if (r_digit >= 4'd9) begin
                            r_digit <= 4'd0;
                            r_carry <= 1'b1;
                        end else begin
                            r_digit <= r_digit + 4'd1;
                        end
                    end else begin
                        if (r_digit == 4'd0) begin
                            r_digit <= 4'd9;
                            r_carry <= 1'b1;
                        end else begin
                            r_digit <= r_digit - 4'd1;
                        end
                    end
                end else begin
                    r_presc <= r_presc + PW'(1);
                end
            end
        end
    end

    assign digit = r_digit;
    assign tick  = r_tick;
    assign carry = r_carry;
    assign {a, b, c, d, e, f, g} = r_seg;

endmodule

// File: tb/tb_sevenseg_digit_counter.sv
// Directed bench for sevenseg_digit_counter with TICK_DIV=4.
// Expected values are hand-derived; outputs are sampled 1 time unit after each rising edge.
module tb_sevenseg_digit_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       blank = 1'b0;
    logic [3:0] digit;
    logic       tick, carry;
    logic       a, b, c, d, e, f, g;
    logic [6:0] seg;

    int checks = 0;
    int failures = 0;

    logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    assign seg = {a, b, c, d, e, f, g};

    always #5 clk = ~clk;

    sevenseg_digit_counter #(
        .TICK_DIV(4),
        .PW      (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .up_dn   (up_dn),
        .load    (load),
        .load_val(load_val),
        .blank   (blank),
        .digit   (digit),
        .tick    (tick),
        .carry   (carry),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .e       (e),
        .f       (f),
        .g       (g)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // 1: reset, then count up through a full decade
        cyc();
        cyc();
        chk("rst_digit", 32'(digit), 32'd0);
        chk("rst_tick_carry", 32'({tick, carry}), 32'd0);
        chk("rst_seg", 32'(seg), 32'(7'b0000001));
        rst = 1'b0;
        en = 1'b1;
        up_dn = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            for (int p = 0; p < 4; p++) begin
                cyc();
                if (p == 0) chk("up_seg", 32'(seg), 32'(seg_tab[(k - 1) % 10]));
                if (p < 3) begin
                    chk("up_idle", 32'({tick, carry}), 32'd0);
                end else begin
                    chk("up_tick", 32'(tick), 32'd1);
                    chk("up_carry", 32'(carry), (k == 10) ? 32'd1 : 32'd0);
                    chk("up_digit", 32'(digit), 32'(k % 10));
                end
            end
        end

        // 2: resync with load 0, then count down 0 -> 9 with carry
        load = 1'b1;
        load_val = 4'd0;
        cyc();
        load = 1'b0;
        up_dn = 1'b0;
        chk("ld0_digit", 32'(digit), 32'd0);
        for (int p = 0; p < 3; p++) begin
            cyc();
            chk("dn_idle", 32'({tick, carry}), 32'd0);
        end
        cyc();
        chk("dn_digit", 32'(digit), 32'd9);
        chk("dn_carry", 32'({tick, carry}), 32'b11);
        cyc();
        chk("dn_seg9", 32'(seg), 32'(7'b0000100));
        chk("dn_carry_clr", 32'(carry), 32'd0);

        // 3: load on a step cycle wins; invalid load ignored
        up_dn = 1'b1;
        cyc();
        cyc();
        chk("pre_ld_idle", 32'(tick), 32'd0);
        load = 1'b1;
        load_val = 4'd7;
        cyc();
        load = 1'b0;
        chk("ld7_digit", 32'(digit), 32'd7);
        chk("ld7_tick_carry", 32'({tick, carry}), 32'd0);
        for (int p = 0; p < 3; p++) begin
            cyc();
            chk("ld7_idle", 32'(tick), 32'd0);
        end
        cyc();
        chk("ld7_next_tick", 32'(tick), 32'd1);
        chk("ld7_next_digit", 32'(digit), 32'd8);
        load = 1'b1;
        load_val = 4'd12;
        cyc();
        load = 1'b0;
        chk("ld12_digit", 32'(digit), 32'd8);

        // 4: en low freezes prescaler and digit
        cyc();
        cyc();
        en = 1'b0;
        for (int p = 0; p < 10; p++) begin
            cyc();
            chk("hold_tick", 32'(tick), 32'd0);
        end
        chk("hold_digit", 32'(digit), 32'd8);
        en = 1'b1;
        cyc();
        chk("resume_idle", 32'(tick), 32'd0);
        cyc();
        chk("resume_tick", 32'(tick), 32'd1);
        chk("resume_digit", 32'(digit), 32'd9);

        // 5: blank forces segments off while counting continues
        blank = 1'b1;
        cyc();
        chk("blank_seg0", 32'(seg), 32'h7f);
        cyc();
        cyc();
        cyc();
        chk("blank_seg3", 32'(seg), 32'h7f);
        chk("blank_digit", 32'(digit), 32'd0);
        chk("blank_carry", 32'(carry), 32'd1);
        blank = 1'b0;
        cyc();
        chk("unblank_seg", 32'(seg), 32'(7'b0000001));

        // 6: reset at digit 5 one cycle before a step
        load = 1'b1;
        load_val = 4'd5;
        cyc();
        load = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("pre_rst_seg5", 32'(seg), 32'(seg_tab[5]));
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rst_digit", 32'(digit), 32'd0);
        chk("mid_rst_tick_carry", 32'({tick, carry}), 32'd0);
        chk("mid_rst_seg", 32'(seg), 32'(7'b0000001));
        for (int p = 0; p < 3; p++) begin
            cyc();
            chk("post_rst_idle", 32'(tick), 32'd0);
        end
        cyc();
        chk("post_rst_tick", 32'(tick), 32'd1);
        chk("post_rst_digit", 32'(digit), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
